// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU.
// Holds the ALUOp codes, the R-type func codes, the top-level FSM state encoding
// and the operation select used by the iterative unit.
package alu_pkg;

  // ALUOp codes
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpRtype = 2'b10;
  localparam logic [1:0] AluOpRsvd  = 2'b11;

  // R-type func codes; anything else yields 0
  localparam logic [5:0] FuncAdd  = 6'd0;
  localparam logic [5:0] FuncSub  = 6'd1;
  localparam logic [5:0] FuncMul  = 6'd2;
  localparam logic [5:0] FuncSll  = 6'd3;
  localparam logic [5:0] FuncSrl  = 6'd4;
  localparam logic [5:0] FuncSra  = 6'd5;
  localparam logic [5:0] FuncDivu = 6'd6;
  localparam logic [5:0] FuncRemu = 6'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    IterMul  = 2'd0,
    IterDivu = 2'd1,
    IterRemu = 2'd2
  } iter_op_e;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/result bundle of the multicycle ALU.
//   start, ALUOp, func, in1, in2 : request side, driven by the master
//   ALUOut, zeroFlag, divZero    : registered result, driven by the ALU
//   busy, done                   : status, driven by the ALU
interface multicycle_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       ALUOp;
  logic [5:0]       func;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] ALUOut;
  logic             zeroFlag;
  logic             divZero;
  logic             busy;
  logic             done;

  modport master (
    output start, ALUOp, func, in1, in2,
    input  ALUOut, zeroFlag, divZero, busy, done
  );

  modport slave (
    input  start, ALUOp, func, in1, in2,
    output ALUOut, zeroFlag, divZero, busy, done
  );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiply and restoring unsigned divide, one bit per cycle.
//   clk, rst : clock, synchronous active-high reset
//   start    : load operands and begin (ignored while running is handled by the caller)
//   op       : IterMul, IterDivu or IterRemu
//   a, b     : multiplicand/dividend and multiplier/divisor
//   done     : high in the cycle of the final step (combinational)
//   result   : value produced by the final step, valid while done is high
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  iter_op_e         op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH);

  // mul: acc = partial product, x = shifted multiplicand, y = shifted multiplier
  // div: acc = partial remainder, x = dividend shifting out / quotient shifting in, y = divisor
  logic             running_q;
  iter_op_e         op_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;

  always_comb begin
    acc_d     = acc_q;
    x_d       = x_q;
    y_d       = y_q;
    rem_shift = {acc_q, x_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, y_q};
    if (op_q == IterMul) begin
      if (y_q[0]) acc_d = acc_q + x_q;
      x_d = x_q << 1;
      y_d = y_q >> 1;
    end else begin
      // Borrow out of the extra top bit means the trial subtraction went negative.
      if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_shift[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign done   = running_q && (cnt_q == CntW'(WIDTH - 1));
  assign result = (op_q == IterDivu) ? x_d : acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      running_q <= 1'b0;
      op_q      <= IterMul;
      cnt_q     <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else if (start) begin
      running_q <= 1'b1;
      op_q      <= op;
      cnt_q     <= '0;
      acc_q     <= '0;
      x_q       <= a;
      y_q       <= b;
    end else if (running_q) begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_q + CntW'(1);
      if (done) running_q <= 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU top: control FSM, single-cycle operations and result registers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request (start, ALUOp, func, in1, in2) and result/status
//              (ALUOut, zeroFlag, divZero, busy, done)
// Single-cycle ops finish one cycle after accept; mul/divu/remu go through
// alu_iter_unit and finish WIDTH+1 cycles after accept.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  multicycle_alu_if.slave  bus
);

  localparam int unsigned ShW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, res_d;
  logic             zero_q;
  logic             div_zero_q, dz_d;
  logic             load;
  logic [WIDTH-1:0] single_res;
  logic [ShW-1:0]   shamt;
  logic             is_rtype, is_mul, is_div, in2_zero, accept;
  logic             iter_start, iter_done;
  iter_op_e         iter_op;
  logic [WIDTH-1:0] iter_result;

  assign shamt    = bus.in2[ShW-1:0];
  assign is_rtype = (bus.ALUOp == AluOpRtype);
  assign is_mul   = is_rtype && (bus.func == FuncMul);
  assign is_div   = is_rtype && ((bus.func == FuncDivu) || (bus.func == FuncRemu));
  assign in2_zero = (bus.in2 == '0);
  assign accept   = bus.start && !rst;

  // Results of everything that completes in one cycle. The divu/remu entries are
  // the divide-by-zero values; nonzero divisors take the iterative path instead.
  always_comb begin
    single_res = '0;
    case (bus.ALUOp)
      AluOpAdd: single_res = bus.in1 + bus.in2;
      AluOpSub: single_res = bus.in1 - bus.in2;
      AluOpRtype: begin
        case (bus.func)
          FuncAdd:  single_res = bus.in1 + bus.in2;
          FuncSub:  single_res = bus.in1 - bus.in2;
          FuncSll:  single_res = bus.in1 << shamt;
          FuncSrl:  single_res = bus.in1 >> shamt;
          FuncSra:  single_res = $unsigned($signed(bus.in1) >>> shamt);
          FuncDivu: single_res = '1;
          FuncRemu: single_res = bus.in1;
          default:  single_res = '0;
        endcase
      end
      AluOpRsvd: single_res = '0;
      default:   single_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    res_d      = single_res;
    dz_d       = 1'b0;
    iter_start = 1'b0;
    iter_op    = IterMul;
    case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) state_d = StIdle;
        if (accept) begin
          if (is_mul) begin
            iter_start = 1'b1;
            iter_op    = IterMul;
            state_d    = StMul;
          end else if (is_div && !in2_zero) begin
            iter_start = 1'b1;
            iter_op    = (bus.func == FuncRemu) ? IterRemu : IterDivu;
            state_d    = StDiv;
          end else begin
            state_d = StDone;
            load    = 1'b1;
            dz_d    = is_div;
          end
        end
      end
      StMul, StDiv: begin
        if (iter_done) begin
          state_d = StDone;
          load    = 1'b1;
          res_d   = iter_result;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      alu_out_q  <= '0;
      zero_q     <= 1'b1;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        alu_out_q  <= res_d;
        zero_q     <= (res_d == '0);
        div_zero_q <= dz_d;
      end
    end
  end

  alu_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .op     (iter_op),
    .a      (bus.in1),
    .b      (bus.in2),
    .done   (iter_done),
    .result (iter_result)
  );

  assign bus.ALUOut   = alu_out_q;
  assign bus.zeroFlag = zero_q;
  assign bus.divZero  = div_zero_q;
  assign bus.busy     = (state_q == StMul) || (state_q == StDiv);
  assign bus.done     = (state_q == StDone);

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width; legal values are powers of two from 8 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to launch an operation with the current operands.
REQ-005 The block SHALL have port ALUOp, input, 2 bits: 00 add, 01 sub, 10 R-type (decode func), 11 reserved (result 0).
REQ-006 The block SHALL have port func, input, 6 bits: R-type code, where 0 add, 1 sub, 2 mul (low WIDTH bits), 3 sll, 4 srl, 5 sra, 6 divu, 7 remu, and others give result 0.
REQ-007 The block SHALL have ports in1 and in2, input, WIDTH bits each: operands; the shift amount is in2[log2(WIDTH)-1:0].
REQ-008 The block SHALL have port ALUOut, output, WIDTH bits: the registered result.
REQ-009 The block SHALL have port zeroFlag, output, 1 bit: high when ALUOut equals 0.
REQ-010 The block SHALL have port divZero, output, 1 bit: high when the completed op was divu or remu with in2 equal to 0.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a multi-cycle op is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: single-cycle pulse marking that a result is valid.

Function
REQ-013 An operation SHALL be accepted on a rising edge where start=1, busy=0 and rst=0; operands, ALUOp and func are captured at that edge.
REQ-014 The block SHALL have FSM states IDLE, MUL, DIV and DONE.
REQ-015 Accepting a single-cycle op (add, sub, shifts, reserved, undefined func) SHALL move the FSM to DONE.
REQ-016 Accepting a mul SHALL move the FSM to MUL.
REQ-017 Accepting a divu or remu with in2 not 0 SHALL move the FSM to DIV.
REQ-018 Accepting a divu or remu with in2 equal to 0 SHALL move the FSM straight to DONE.
REQ-019 DONE SHALL last exactly one cycle, with done=1, then move to IDLE unless a new start is accepted in that same cycle.
REQ-020 Latency SHALL be measured from the accept edge k: single-cycle ops have done=1 in cycle k+1, and mul, divu and remu have done=1 in cycle k+WIDTH+1.
REQ-021 MUL SHALL use iterative shift-add, one multiplier bit per cycle, for WIDTH cycles, and the result SHALL be the product mod 2^WIDTH.
REQ-022 DIV SHALL use iterative restoring unsigned division, one quotient bit per cycle, for WIDTH cycles; divu returns the quotient and remu the remainder.
REQ-023 Divide-by-zero SHALL give divu result all-ones and remu result in1, with divZero=1.
REQ-024 add and sub SHALL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-025 sra SHALL replicate in1[WIDTH-1]; sll and srl SHALL fill with zeros.
REQ-026 ALUOut, zeroFlag and divZero SHALL update only when the FSM enters DONE and SHALL hold until the next entry to DONE.
REQ-027 busy SHALL equal 1 exactly in MUL and DIV.
REQ-028 A start asserted while busy=1 SHALL be ignored and not queued, and operand changes during MUL or DIV SHALL not affect the result.
REQ-029 A start asserted in the DONE cycle SHALL be accepted, giving back-to-back operation with one done pulse per op.

Reset
REQ-030 While rst=1 on a rising edge, the FSM SHALL go to IDLE, with ALUOut=0, zeroFlag=1, divZero=0, busy=0 and done=0.
REQ-031 rst SHALL override start in the same cycle.
REQ-032 A reset asserted mid-operation in MUL or DIV SHALL abort the operation without producing a done pulse.
REQ-033 Iteration counters and partial products or remainders SHALL be cleared on reset.

Structure
REQ-034 The shared package alu_pkg SHALL hold the ALUOp codes, the func codes and the FSM state encoding.
REQ-035 The iterative datapath SHALL be one sub-module, alu_iter_unit, that performs mul, divu and remu with its own start/done, and the top level SHALL hold the FSM, the single-cycle ops and the result registers.

Verification (WIDTH=32 unless stated)
REQ-036 Scenario 1: ALUOp=00, in1=15, in2=24, start pulse -> next cycle done=1, ALUOut=39, zeroFlag=0.
REQ-037 Scenario 2: ALUOp=01, in1=15, in2=15 -> ALUOut=0, zeroFlag=1; then in1=0, in2=1 -> ALUOut=0xFFFFFFFF.
REQ-038 Scenario 3: func=2, in1=0x10000, in2=0x10003 -> busy for 32 cycles, done at k+33, ALUOut=0x00030000; a start issued mid-op is ignored.
REQ-039 Scenario 4: func=6 then func=7, in1=100, in2=7 -> results 14 then 2; in2=0 -> divu gives 0xFFFFFFFF with divZero=1, and remu gives 100 with divZero=1.
REQ-040 Scenario 5: func=5, in1=0x80000000, in2=35 -> ALUOut=0xF0000000 (shift amount 3); func=3 -> 0x00000000.
REQ-041 Scenario 6: rst asserted during MUL -> busy=0 the next cycle, no done pulse, ALUOut=0, zeroFlag=1; repeat scenario 1 with WIDTH=8.
